// File: rtl/rr_arb_pkg.sv
// Shared types and the rotating-priority winner search for the four-way round-robin arbiter.
// The search starts at the priority pointer and wraps modulo NREQ.
package rr_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    // Offsets are scanned high-to-low so the closest set bit to ptr overwrites any farther one.
    function automatic logic [IDX_W-1:0] next_winner(input logic [NREQ-1:0]  req,
                                                     input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder with enable; drives the grant vector from the registered index.
// All-zero output when disabled so downstream selects never see two hot lines.
module dec2to4 (
    input  logic [1:0] i,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with an optional per-tenure hold limit.
// Every tenure ends in one idle cycle; outputs derive only from registers.
module rr_arb4
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam int unsigned      CntW    = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD) + 1;
    localparam logic [CntW-1:0]  CntLast = (MAX_HOLD == 0) ? '0 : CntW'(MAX_HOLD - 1);
    localparam bit               Limited = (MAX_HOLD != 0);

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [CntW-1:0]  cnt_q;
    logic             timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_idx_q <= next_winner(req, ptr_q);
                        cnt_q     <= '0;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    // Release outranks expiry: a dropped request never raises timeout.
                    if (!req[gnt_idx_q]) begin
                        state_q <= IDLE;
                        ptr_q   <= gnt_idx_q + IDX_W'(1);
                    end else if (Limited && (cnt_q == CntLast)) begin
                        state_q   <= IDLE;
                        ptr_q     <= gnt_idx_q + IDX_W'(1);
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_vld = (state_q == GRANT);
    assign gnt_idx = gnt_idx_q;
    assign timeout = timeout_q;

    dec2to4 u_dec (
        .i  (gnt_idx_q),
        .en (gnt_vld),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: three instances (hold limits 8, 4 and 0) checked against a
// behavioural model of the arbitration rules plus fixed expected sequences.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic [3:0] req   [3];
    logic [3:0] gnt   [3];
    logic [1:0] idx   [3];
    logic       vld   [3];
    logic       to    [3];

    int checks   = 0;
    int failures = 0;

    // Model state: busy flag, owner, priority start, cycles held so far, timeout pulse.
    bit m_busy  [3];
    int m_owner [3];
    int m_ptr   [3];
    int m_held  [3];
    bit m_to    [3];
    int limit   [3] = '{8, 4, 0};

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]),
        .gnt(gnt[0]), .gnt_idx(idx[0]), .gnt_vld(vld[0]), .timeout(to[0])
    );
    rr_arb4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]),
        .gnt(gnt[1]), .gnt_idx(idx[1]), .gnt_vld(vld[1]), .timeout(to[1])
    );
    rr_arb4 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n[2]), .req(req[2]),
        .gnt(gnt[2]), .gnt_idx(idx[2]), .gnt_vld(vld[2]), .timeout(to[2])
    );

    function automatic void model_reset(int d);
        m_busy[d]  = 1'b0;
        m_owner[d] = 0;
        m_ptr[d]   = 0;
        m_held[d]  = 0;
        m_to[d]    = 1'b0;
    endfunction

    function automatic void model_edge(int d);
        logic [3:0] r;
        bit         pulse;
        r     = req[d];
        pulse = 1'b0;
        if (!rst_n[d]) begin
            model_reset(d);
            return;
        end
        if (!m_busy[d]) begin
            if (r != 4'b0000) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(m_ptr[d] + k) % 4]) m_owner[d] = (m_ptr[d] + k) % 4;
                end
                m_busy[d] = 1'b1;
                m_held[d] = 1;
            end
        end else if (!r[m_owner[d]]) begin
            m_busy[d] = 1'b0;
            m_ptr[d]  = (m_owner[d] + 1) % 4;
        end else if (limit[d] != 0 && m_held[d] == limit[d]) begin
            m_busy[d] = 1'b0;
            m_ptr[d]  = (m_owner[d] + 1) % 4;
            pulse     = 1'b1;
        end else begin
            m_held[d]++;
        end
        m_to[d] = pulse;
    endfunction

    function automatic logic [7:0] observed(int d);
        return {vld[d], to[d], idx[d], gnt[d]};
    endfunction

    function automatic logic [7:0] expected(int d);
        logic [3:0] onehot;
        logic [1:0] own;
        own    = 2'(m_owner[d]);
        onehot = m_busy[d] ? 4'(1 << m_owner[d]) : 4'b0000;
        return {m_busy[d], m_to[d], own, onehot};
    endfunction

    // One clock edge for all instances; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_edge(d);
        #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0;
            req[d]   = 4'b1111;
            model_reset(d);
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observed(d) !== 8'h00) begin
                failures++;
                $display("FAIL reset_async d=%0d got=%b want=%b", d, observed(d), 8'h00);
            end
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observed(d) !== 8'h00) begin
                failures++;
                $display("FAIL reset_held d=%0d got=%b want=%b", d, observed(d), 8'h00);
            end
            req[d]   = 4'b0000;
            rst_n[d] = 1'b1;
        end
        repeat (2) step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (observed(d) !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle d=%0d got=%b want=%b", d, observed(d), 8'h00);
            end
        end
    endtask

    task automatic test_single();
        int cycles = 0;
        req[0] = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) req[0] = 4'b0000;
            step();
            if (gnt[0] == 4'b0100) cycles++;
            checks++;
            if (observed(0) !== expected(0) || to[0] !== 1'b0) begin
                failures++;
                $display("FAIL single c=%0d got=%b want=%b", c, observed(0), expected(0));
            end
        end
        checks++;
        if (cycles != 3) begin
            failures++;
            $display("FAIL single_len got=%0d want=3", cycles);
        end
    endtask

    task automatic test_contention();
        logic [3:0] want_g;
        logic       want_t;
        req[1] = 4'b1111;
        for (int i = 0; i < 25; i++) begin
            step();
            want_g = (i % 5 < 4) ? 4'(1 << ((i / 5) % 4)) : 4'b0000;
            want_t = (i % 5 == 4);
            checks++;
            if (gnt[1] !== want_g || to[1] !== want_t || observed(1) !== expected(1)) begin
                failures++;
                $display("FAIL contention i=%0d got gnt=%b to=%b want gnt=%b to=%b",
                         i, gnt[1], to[1], want_g, want_t);
            end
        end
        req[1] = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        req[0] = 4'b1000;
        step();
        checks++;
        if (gnt[0] !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_g3 got=%b want=%b", gnt[0], 4'b1000);
        end
        req[0] = 4'b0000;
        step();
        req[0] = 4'b0011;
        step();
        checks++;
        if (gnt[0] !== 4'b0001 || observed(0) !== expected(0)) begin
            failures++;
            $display("FAIL wrap_g0 got=%b want=%b", gnt[0], 4'b0001);
        end
        req[0] = 4'b0000;
        step();
        req[0] = 4'b0011;
        step();
        checks++;
        if (gnt[0] !== 4'b0010 || observed(0) !== expected(0)) begin
            failures++;
            $display("FAIL wrap_g1 got=%b want=%b", gnt[0], 4'b0010);
        end
        req[0] = 4'b0000;
        step();
    endtask

    task automatic test_async_reset();
        req[0] = 4'b0010;
        step();
        checks++;
        if (gnt[0] !== 4'b0010) begin
            failures++;
            $display("FAIL arst_pre got=%b want=%b", gnt[0], 4'b0010);
        end
        #2;
        rst_n[0] = 1'b0;
        model_reset(0);
        #1;
        checks++;
        if (gnt[0] !== 4'b0000 || vld[0] !== 1'b0 || idx[0] !== 2'b00) begin
            failures++;
            $display("FAIL arst_drop got gnt=%b vld=%b want gnt=0000 vld=0", gnt[0], vld[0]);
        end
        req[0] = 4'b1111;
        step();
        rst_n[0] = 1'b1;
        step();
        checks++;
        if (gnt[0] !== 4'b0001 || observed(0) !== expected(0)) begin
            failures++;
            $display("FAIL arst_restart got=%b want=%b", gnt[0], 4'b0001);
        end
        req[0] = 4'b0000;
        step();
    endtask

    task automatic test_unlimited();
        int held = 0;
        req[2] = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            step();
            req[2] = 4'b0011;
            if (gnt[2] === 4'b0010 && to[2] === 1'b0) held++;
        end
        checks++;
        if (held != 20) begin
            failures++;
            $display("FAIL unlimited_hold got=%0d want=20", held);
        end
        req[2] = 4'b0001;
        step();
        checks++;
        if (gnt[2] !== 4'b0000 || to[2] !== 1'b0) begin
            failures++;
            $display("FAIL unlimited_gap got gnt=%b to=%b want gnt=0000 to=0", gnt[2], to[2]);
        end
        step();
        checks++;
        if (gnt[2] !== 4'b0001 || observed(2) !== expected(2)) begin
            failures++;
            $display("FAIL unlimited_next got=%b want=%b", gnt[2], 4'b0001);
        end
        req[2] = 4'b0000;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                rst_n[d] = ($urandom_range(0, 99) != 0);
                // Sticky requests give long tenures so the hold limits are exercised.
                if ($urandom_range(0, 3) == 0) req[d] = 4'($urandom_range(0, 15));
            end
            step();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (observed(d) !== expected(d)) begin
                    failures++;
                    $display("FAIL random c=%0d d=%0d got=%b want=%b",
                             c, d, observed(d), expected(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_async_reset();
        test_unlimited();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that shares one downstream resource slot among four clients. It selects a winner, holds the grant until the winner releases or a hold limit expires, then rotates priority. Grants come out both as a 2-bit index and as a one-hot vector, produced by an internal 2-to-4 decoder. It sits in front of any decoded-select resource, so the select is always one-hot or all-zero.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure; 0 disables the limit; legal range 0..255
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit k = requester k, level-sensitive
- gnt  output  4  one-hot grant; 4'b0000 when idle
- gnt_idx  output  2  encoded index of current grantee; holds last value when idle
- gnt_vld  output  1  high while a grant is active
- timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD

## Operation
- State machine with two states: IDLE and GRANT.
- Internal regs: state, ptr[1:0] (priority start), cnt (width $clog2(MAX_HOLD)+1, minimum 1), gnt_idx, timeout.
- IDLE: gnt_vld=0, gnt=0000. At an edge with req!=0, scan ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins. Then gnt_idx<=winner, cnt<=0, state<=GRANT.
- GRANT: evaluated at each edge, in this priority order:
  - req[gnt_idx]==0 (release): state<=IDLE, ptr<=gnt_idx+1 (wraps 3->0).
  - MAX_HOLD!=0 and cnt==MAX_HOLD-1 (expiry): state<=IDLE, ptr<=gnt_idx+1, timeout<=1.
  - Otherwise: cnt<=cnt+1.
- Other requesters' bits are ignored during GRANT. There is no preemption.
- timeout is high for exactly one cycle, which is the IDLE cycle after expiry. It is cleared at the next edge.
- Both release and expiry pass through one IDLE cycle, so consecutive tenures are separated by at least one gnt=0000 cycle.
- ptr is only a priority start point. If the expired requester is the sole requester, it is granted again after the idle cycle.
- gnt = decode(gnt_idx) gated by gnt_vld. It is derived purely from registered state and is glitch-free.
- Reset (asynchronous, immediate, no clock needed): state=IDLE, ptr=0, cnt=0, gnt_idx=00, gnt_vld=0, gnt=0000, timeout=0.
- Reset asserted mid-tenure: grant drops immediately. After reset release, arbitration restarts from ptr=0.

## Timing
- Request latency is 1 cycle: req sampled high at edge t while IDLE gives gnt valid after edge t.
- Release latency is 1 cycle: req[gnt_idx] sampled low at edge t gives gnt=0000 after edge t.
- A tenure lasts min(cycles until release, MAX_HOLD) cycles.
- Minimum request-to-request turnaround for a different winner is 1 idle cycle.
- Worst-case wait for a continuously requesting client with all four requesting is 3*(MAX_HOLD+1) cycles.
- All outputs are registered or decoded from registers. There are no combinational paths from req to any output.

## Structure
- Package rr_arb_pkg:
  - NREQ=4 and IDX_W=2
  - state enum {IDLE, GRANT}
  - a function next_winner(req, ptr) returning the 2-bit index
- Sub-module dec2to4 (input [1:0] i, input en, output [3:0] y) produces gnt from gnt_idx and gnt_vld.
- The top level holds the FSM, ptr, cnt and timeout registers.

## Test plan
- Reset: hold rst_n=0 with req=1111 for 3 edges -> gnt=0000, gnt_vld=0, gnt_idx=00, timeout=0. Release reset with req=0000 -> stays idle.
- Single requester: req=0100 held 3 cycles then 0000, with MAX_HOLD=8 -> gnt=0100 for exactly 3 cycles starting one edge after req, then 0000, ptr=3, timeout never set.
- Full contention: req=1111 constant, MAX_HOLD=4 -> sequence 0001×4, 0000 (timeout=1), 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001…
- Wrap priority: grant requester 3, release, then req=0011 -> gnt=0001. After releasing that, req=0011 -> gnt=0010.
- Async reset mid-tenure: gnt=0010 active, rst_n falls between edges -> gnt=0000 and gnt_vld=0 before the next edge. After release with req=1111 -> gnt=0001.
- Unlimited hold: MAX_HOLD=0, req=0010 for 20 cycles with req[0]=1 also set -> gnt=0010 for all 20 cycles, timeout stays 0, then 0000 for one cycle, then 0001.
